// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive control unit for the USB receiver.
// Sequences the bit/byte timer through a packet: checks the SYNC byte,
// counts data bytes and bits, flags EOP misalignment and over-length
// packets, and issues one-cycle FIFO write strobes.
//
// Ports
//   clk            in   system clock, rising edge
//   n_rst          in   asynchronous active-low reset
//   d_edge         in   one-cycle pulse: transition seen on D+/D-
//   eop            in   level: SE0 currently on the bus
//   shift_enable   in   one-cycle pulse: bit sample point from the timer
//   byte_received  in   pulse: 8 bits shifted since the last clear
//   rcv_data[7:0]  in   parallel byte from the shift register
//   rcving         out  high while a packet is being received (gates timer)
//   w_enable       out  one-cycle FIFO write strobe for rcv_data
//   r_error        out  receive error, sticky until the next packet starts
module usb_rx_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'h80,
    parameter int unsigned MAX_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_edge,
    input  logic       eop,
    input  logic       shift_enable,
    input  logic       byte_received,
    input  logic [7:0] rcv_data,
    output logic       rcving,
    output logic       w_enable,
    output logic       r_error
);

    localparam int unsigned CNT_W = $clog2(MAX_BYTES + 1);
    localparam int unsigned BIT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        RCV_SYNC,
        CHK_SYNC,
        RCV_DATA,
        STORE,
        EOP_OK,
        ERR_EOP,
        ERR_IDLE
    } state_t;

    state_t             state, state_n;
    logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_n;
    logic               rcving_n, w_enable_n, r_error_n;
    logic               se_eop_c;

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            rcving   <= 1'b0;
            w_enable <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            byte_cnt <= byte_cnt_n;
            rcving   <= rcving_n;
            w_enable <= w_enable_n;
            r_error  <= r_error_n;
        end
    end

    // Next state, counters, and outputs decoded from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        byte_cnt_n = byte_cnt;
        se_eop_c   = eop && shift_enable;

        case (state)
            IDLE: begin
                if (d_edge) state_n = RCV_SYNC;
            end
            RCV_SYNC: begin
                if (byte_received)  state_n = CHK_SYNC;
                else if (se_eop_c)  state_n = ERR_EOP;
            end
            CHK_SYNC: begin
                if (rcv_data == SYNC_BYTE) begin
                    state_n    = RCV_DATA;
                    bit_cnt_n  = '0;
                    byte_cnt_n = '0;
                end else begin
                    state_n = ERR_EOP;
                end
            end
            RCV_DATA: begin
                // A completed byte outranks a coincident SE0 sample; the
                // second SE0 sample of the EOP is caught after STORE.
                if (byte_received) begin
                    if (byte_cnt == CNT_W'(MAX_BYTES)) begin
                        state_n = ERR_EOP;
                    end else begin
                        state_n    = STORE;
                        byte_cnt_n = byte_cnt + CNT_W'(1);
                        bit_cnt_n  = '0;
                    end
                end else if (se_eop_c) begin
                    state_n = (bit_cnt == '0) ? EOP_OK : ERR_EOP;
                end else if (shift_enable) begin
                    bit_cnt_n = bit_cnt + BIT_W'(1);
                end
            end
            STORE: begin
                state_n = RCV_DATA;
            end
            EOP_OK: begin
                if (d_edge) state_n = IDLE;
            end
            ERR_EOP: begin
                if (se_eop_c) state_n = ERR_IDLE;
            end
            ERR_IDLE: begin
                if (d_edge) state_n = RCV_SYNC;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        rcving_n   = (state_n == RCV_SYNC) || (state_n == CHK_SYNC) ||
                     (state_n == RCV_DATA) || (state_n == STORE)    ||
                     (state_n == ERR_EOP);
        w_enable_n = (state_n == STORE);

        // Sticky error: set in the error states, cleared at packet start.
        r_error_n = r_error;
        if ((state_n == ERR_EOP) || (state_n == ERR_IDLE)) begin
            r_error_n = 1'b1;
        end else if (state_n == RCV_SYNC) begin
            r_error_n = 1'b0;
        end
    end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Testbench for usb_rx_ctrl: drives whole packets (SYNC, data bytes,
// optional stray bits, EOP) and checks strobes and flags against
// packet-level expectations.
module tb_usb_rx_ctrl;

    localparam int unsigned MAX = 4;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       d_edge;
    logic       eop;
    logic       shift_enable;
    logic       byte_received;
    logic [7:0] rcv_data;
    logic       rcving;
    logic       w_enable;
    logic       r_error;

    int n_tests = 0;
    int n_fail  = 0;

    usb_rx_ctrl #(
        .SYNC_BYTE (8'h80),
        .MAX_BYTES (MAX)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .d_edge        (d_edge),
        .eop           (eop),
        .shift_enable  (shift_enable),
        .byte_received (byte_received),
        .rcv_data      (rcv_data),
        .rcving        (rcving),
        .w_enable      (w_enable),
        .r_error       (r_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; w_enable must reflect whether this
    // cycle's byte_received should produce a FIFO write.
    task automatic tick(input logic de, input logic se, input logic br, input logic exp_we);
        d_edge        = de;
        shift_enable  = se;
        byte_received = br;
        @(posedge clk);
        #1;
        chk("w_enable", w_enable, exp_we);
        d_edge        = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
    endtask

    // Idle cycles between bit samples, optionally with stray line edges.
    task automatic gap(input int n, input logic noise);
        for (int i = 0; i < n; i++) begin
            tick(noise && ($urandom_range(0, 3) == 0), 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Eight bit times; the last sample coincides with byte_received.
    task automatic send_byte(input logic [7:0] b, input logic we_ok, input logic eop_on_last);
        for (int i = 0; i < 8; i++) begin
            gap($urandom_range(2, 4), 1'b1);
            if (i == 7) begin
                rcv_data = b;
                if (eop_on_last) eop = 1'b1;
                tick(1'b0, 1'b1, 1'b1, we_ok);
            end else begin
                tick(1'b0, 1'b1, 1'b0, 1'b0);
            end
        end
    endtask

    // Full packet: expectations come from the packet's shape alone.
    task automatic run_packet(input logic [7:0] sync, input int n, input int partial,
                              input logic coinc);
        logic good_sync, err_pre, err;
        good_sync = (sync == 8'h80);
        err_pre   = !good_sync || (n > MAX);
        err       = err_pre || (partial != 0);

        eop = 1'b0;
        gap(2, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        chk("rcving_start", rcving, 1'b1);
        chk("r_error_start", r_error, 1'b0);

        send_byte(sync, 1'b0, 1'b0);
        chk("rcving_sync", rcving, 1'b1);
        chk("r_error_chk", r_error, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        chk("r_error_after_sync", r_error, !good_sync);

        for (int k = 1; k <= n; k++) begin
            send_byte(8'($urandom), good_sync && (k <= MAX), coinc && (k == n));
        end

        if (coinc) begin
            chk("rcving_store_coinc", rcving, 1'b1);
            gap($urandom_range(2, 4), 1'b0);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            chk("rcving_eop_coinc", rcving, 1'b0);
            chk("r_error_eop_coinc", r_error, 1'b0);
        end else begin
            for (int i = 0; i < partial; i++) begin
                gap($urandom_range(2, 4), 1'b0);
                tick(1'b0, 1'b1, 1'b0, 1'b0);
            end
            eop = 1'b1;
            gap($urandom_range(2, 4), 1'b0);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            chk("rcving_se0_1", rcving, !err_pre && (partial != 0));
            chk("r_error_se0_1", r_error, err);
            gap($urandom_range(2, 4), 1'b0);
            tick(1'b0, 1'b1, 1'b0, 1'b0);
            chk("rcving_se0_2", rcving, 1'b0);
            chk("r_error_se0_2", r_error, err);
        end

        gap(2, 1'b0);
        eop = 1'b0;
        gap(2, 1'b0);
        if (!err) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            chk("rcving_idle", rcving, 1'b0);
            chk("r_error_idle", r_error, 1'b0);
        end else begin
            chk("rcving_err_idle", rcving, 1'b0);
            chk("r_error_held", r_error, 1'b1);
        end
        gap(3, 1'b0);
    endtask

    task automatic pulse_reset();
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_rcving", rcving, 1'b0);
        chk("rst_w_enable", w_enable, 1'b0);
        chk("rst_r_error", r_error, 1'b0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    initial begin
        logic [7:0] s;
        int         n, partial;
        logic       coinc;

        n_rst         = 1'b1;
        d_edge        = 1'b0;
        eop           = 1'b0;
        shift_enable  = 1'b0;
        byte_received = 1'b0;
        rcv_data      = 8'h00;
        #2;
        n_rst = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_rcving", rcving, 1'b0);
        chk("reset_w_enable", w_enable, 1'b0);
        chk("reset_r_error", r_error, 1'b0);
        n_rst = 1'b1;
        gap(2, 1'b0);

        // Reset while a write strobe is high in the middle of data
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        send_byte(8'h80, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h11, 1'b1, 1'b0);
        pulse_reset();

        run_packet(8'h80, 2, 0, 1'b0);   // good packet
        run_packet(8'h81, 1, 0, 1'b0);   // bad SYNC
        run_packet(8'h80, 1, 3, 1'b0);   // EOP 3 bits into byte 2
        run_packet(8'h80, 5, 0, 1'b0);   // one byte over the limit
        run_packet(8'h80, 2, 0, 1'b1);   // byte and SE0 sample coincide
        run_packet(8'h80, 0, 0, 1'b0);   // SYNC only
        run_packet(8'h80, MAX, 0, 1'b0); // exactly at the limit

        // Reset clears a held error flag
        pulse_reset();
        gap(2, 1'b0);

        for (int p = 0; p < 30; p++) begin
            s = 8'h80;
            if ($urandom_range(0, 4) == 0) begin
                s = 8'($urandom);
                if (s == 8'h80) s = 8'h81;
            end
            n       = int'($urandom_range(0, MAX + 2));
            partial = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            coinc   = (s == 8'h80) && (n >= 1) && (n <= MAX) && (partial == 0) &&
                      ($urandom_range(0, 3) == 0);
            run_packet(s, n, partial, coinc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
